// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: row strobing, full-scan debounce, press FSM and a one-deep valid/ready event buffer.
// Optional auto-repeat is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 5,
  parameter int unsigned REPEAT_SCANS   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS == 0 || REPEAT_SCANS == 0) begin : g_bad_params
    $error("keypad_scan_ctrl: SCAN_DIV must be >= 2, DEBOUNCE_SCANS and REPEAT_SCANS >= 1");
  end

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESSED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [15:0]      snapshot;
  logic             eval_q;
  logic [4:0]       prev_cand;
  logic [DEB_W-1:0] deb_cnt;
  logic [3:0]       acc_key;
  logic [3:0]       acc_key_next;

  logic             sample_c;
  logic [4:0]       hit_cnt_c;
  logic [3:0]       hit_idx_c;
  logic [4:0]       cand_c;
  logic [DEB_W-1:0] deb_next_c;
  logic             stable_c;
  logic [4:0]       accepted_c;
  logic             change_c;
  logic             press_c;
  logic             rep_fire_c;
  logic             event_c;
  logic [4:0]       event_code_c;

  // Snapshot bit index is 4*row + col; map it to the key nibble.
  function automatic logic [3:0] key_nibble(input logic [3:0] idx);
    logic [3:0] nib;
    case (idx)
      4'd0:    nib = 4'h1;
      4'd1:    nib = 4'h2;
      4'd2:    nib = 4'h3;
      4'd3:    nib = 4'hA;
      4'd4:    nib = 4'h4;
      4'd5:    nib = 4'h5;
      4'd6:    nib = 4'h6;
      4'd7:    nib = 4'hB;
      4'd8:    nib = 4'h7;
      4'd9:    nib = 4'h8;
      4'd10:   nib = 4'h9;
      4'd11:   nib = 4'hC;
      4'd12:   nib = 4'hE;
      4'd13:   nib = 4'h0;
      4'd14:   nib = 4'hF;
      default: nib = 4'hD;
    endcase
    return nib;
  endfunction

  assign sample_c = (div == DIV_LAST);

  // Row sequencing: sample columns at the end of each slot, then advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      row_idx  <= 2'd0;
      row_out  <= 4'b0001;
      snapshot <= 16'h0000;
      eval_q   <= 1'b0;
    end else begin
      eval_q <= sample_c && (row_idx == 2'd3);
      if (sample_c) begin
        div                            <= '0;
        row_idx                        <= row_idx + 2'd1;
        row_out                        <= {row_out[2:0], row_out[3]};
        snapshot[{row_idx, 2'b00} +: 4] <= col_in;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Per-scan candidate: exactly one closed switch is a key, anything else is idle.
  always_comb begin
    hit_cnt_c = 5'd0;
    hit_idx_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        hit_cnt_c = hit_cnt_c + 5'd1;
        hit_idx_c = 4'(i);
      end
    end
    cand_c = (hit_cnt_c == 5'd1) ? {1'b1, key_nibble(hit_idx_c)} : 5'b00000;
  end

  always_comb begin
    deb_next_c = DEB_W'(1);
    if (cand_c == prev_cand) begin
      deb_next_c = (deb_cnt == DEB_MAX) ? DEB_MAX : deb_cnt + DEB_W'(1);
    end
  end

  assign stable_c   = eval_q && (deb_next_c == DEB_MAX);
  assign accepted_c = (state == S_PRESSED) ? {1'b1, acc_key} : 5'b00000;
  assign change_c   = stable_c && (cand_c != accepted_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cand <= 5'b00000;
      deb_cnt   <= '0;
    end else if (eval_q) begin
      prev_cand <= cand_c;
      deb_cnt   <= deb_next_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      acc_key <= 4'h0;
    end else begin
      state   <= state_next;
      acc_key <= acc_key_next;
    end
  end

  // Accepted-state transitions; a press event fires on entering or switching keys.
  always_comb begin
    state_next   = state;
    acc_key_next = acc_key;
    press_c      = 1'b0;
    if (change_c) begin
      case (state)
        S_IDLE: begin
          state_next   = S_PRESSED;
          acc_key_next = cand_c[3:0];
          press_c      = 1'b1;
        end
        S_PRESSED: begin
          if (cand_c[4]) begin
            acc_key_next = cand_c[3:0];
            press_c      = 1'b1;
          end else begin
            state_next   = S_IDLE;
            acc_key_next = 4'h0;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_SCANS);

  logic [REP_W-1:0] rep_cnt;

  assign rep_fire_c = eval_q && !change_c && (state == S_PRESSED) &&
                      ((rep_cnt + REP_W'(1)) == REP_PERIOD);

  // Counts full scans while a key stays accepted; cleared by any accepted change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (eval_q) begin
      if (change_c) begin
        rep_cnt <= '0;
      end else if (state == S_PRESSED) begin
        rep_cnt <= rep_fire_c ? '0 : rep_cnt + REP_W'(1);
      end
    end
  end
`else
  assign rep_fire_c = 1'b0;
`endif

  assign event_c      = press_c || rep_fire_c;
  assign event_code_c = {1'b1, acc_key_next};

  // One-deep output buffer; a same-cycle handshake frees the slot for a new event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= 5'b00000;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (event_c) begin
      if (!key_valid || key_ready) begin
        key_code  <= event_code_c;
        key_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_code  <= 5'b00000;
      key_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_held <= 1'b0;
    end else begin
      key_held <= (state_next == S_PRESSED);
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with a behavioural keypad matrix driving col_in from row_out.
module tb_keypad_scan_ctrl;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_SCANS = 3;
  localparam int unsigned REPEAT_SCANS   = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;

  logic [15:0] keys;
  logic [4:0]  exp_q[$];
  int          n_checks;
  int          n_errors;
  int          n_events;
  int          ev_base;

  keypad_scan_ctrl #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_SCANS  (REPEAT_SCANS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: the strobed row's closed switches appear on the columns.
  always_comb begin
    case (row_out)
      4'b0001: col_in = keys[3:0];
      4'b0010: col_in = keys[7:4];
      4'b0100: col_in = keys[11:8];
      4'b1000: col_in = keys[15:12];
      default: col_in = 4'b0000;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer side of the scoreboard.
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      n_events++;
      check_eq("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("evt_code", 32'(key_code), 32'(exp_q.pop_front()));
    end
  end

  // Waits for n full scans to complete, then for the evaluation cycle to commit.
  task automatic wait_scans(input int n);
    for (int i = 0; i < n; i++) begin
      int budget;
      bit seen3;
      bit done;
      budget = 0;
      seen3  = 1'b0;
      done   = 1'b0;
      while (!done && budget < 200) begin
        @(negedge clk);
        budget++;
        if (row_out == 4'b1000) seen3 = 1'b1;
        else if (seen3 && row_out == 4'b0001) done = 1'b1;
      end
      check_eq("scan_done", 32'(done), 32'd1);
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_row", 32'(row_out), 32'h1);
    check_eq("rst_valid", 32'(key_valid), 32'h0);
    check_eq("rst_code", 32'(key_code), 32'h0);
    check_eq("rst_held", 32'(key_held), 32'h0);
    check_eq("rst_ovf", 32'(overflow), 32'h0);
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_scans(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    n_events  = 0;
    keys      = 16'h0000;
    key_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check_eq("init_row", 32'(row_out), 32'h1);
    check_eq("init_valid", 32'(key_valid), 32'h0);
    check_eq("init_ovf", 32'(overflow), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_scans(1);

    // Pending event lost on an asynchronous mid-slot reset.
    keys = 16'h0400;
    wait_scans(3);
    check_eq("t1_valid", 32'(key_valid), 32'h1);
    check_eq("t1_code", 32'(key_code), 32'h19);
    check_eq("t1_held", 32'(key_held), 32'h1);
    pulse_reset();

    // Clean '5' press and release.
    @(posedge clk);
    #1 key_ready = 1'b1;
    ev_base = n_events;
    exp_q.push_back(5'b10101);
    if (REP_EN) exp_q.push_back(5'b10101);
    keys = 16'h0020;
    wait_scans(2);
    check_eq("t2_held_early", 32'(key_held), 32'h0);
    wait_scans(3);
    check_eq("t2_held", 32'(key_held), 32'h1);
    keys = 16'h0000;
    wait_scans(2);
    check_eq("t2_held_rel2", 32'(key_held), 32'h1);
    wait_scans(1);
    check_eq("t2_held_rel3", 32'(key_held), 32'h0);
    repeat (2) @(negedge clk);
    check_eq("t2_events", 32'(n_events - ev_base), REP_EN ? 32'd2 : 32'd1);

    // '#' bouncing on alternate scans.
    ev_base = n_events;
    for (int i = 0; i < 5; i++) begin
      keys = 16'h4000;
      wait_scans(1);
      keys = 16'h0000;
      wait_scans(1);
      check_eq("t3_held", 32'(key_held), 32'h0);
    end
    check_eq("t3_events", 32'(n_events - ev_base), 32'd0);

    // Ghosting '1'+'2', then '2' released.
    ev_base = n_events;
    keys = 16'h0003;
    wait_scans(6);
    check_eq("t4_ghost_held", 32'(key_held), 32'h0);
    check_eq("t4_ghost_events", 32'(n_events - ev_base), 32'd0);
    exp_q.push_back(5'b10001);
    keys = 16'h0001;
    wait_scans(3);
    check_eq("t4_held", 32'(key_held), 32'h1);
    keys = 16'h0000;
    wait_scans(4);
    check_eq("t4_events", 32'(n_events - ev_base), 32'd1);

    // Backpressure: second press dropped while 'A' is pending.
    @(posedge clk);
    #1 key_ready = 1'b0;
    keys = 16'h0008;
    wait_scans(3);
    check_eq("t5_valid", 32'(key_valid), 32'h1);
    check_eq("t5_code_a", 32'(key_code), 32'h1A);
    keys = 16'h0000;
    wait_scans(3);
    check_eq("t5_held_idle", 32'(key_held), 32'h0);
    check_eq("t5_ovf_before", 32'(overflow), 32'h0);
    keys = 16'h8000;
    wait_scans(3);
    check_eq("t5_code_hold", 32'(key_code), 32'h1A);
    check_eq("t5_ovf", 32'(overflow), 32'h1);
    check_eq("t5_held_d", 32'(key_held), 32'h1);
    exp_q.push_back(5'b11010);
    @(posedge clk);
    #1 key_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_valid_clr", 32'(key_valid), 32'h0);
    check_eq("t5_code_clr", 32'(key_code), 32'h0);
    check_eq("t5_ovf_sticky", 32'(overflow), 32'h1);
    keys = 16'h0000;
    wait_scans(4);
    pulse_reset();

    // Long hold of '0': one event, plus periodic repeats when enabled.
    ev_base = n_events;
    for (int i = 0; i < (REP_EN ? 5 : 1); i++) exp_q.push_back(5'b10000);
    keys = 16'h2000;
    wait_scans(20);
    check_eq("t6_held", 32'(key_held), 32'h1);
    keys = 16'h0000;
    wait_scans(4);
    repeat (2) @(negedge clk);
    check_eq("t6_events", 32'(n_events - ev_base), REP_EN ? 32'd5 : 32'd1);
    check_eq("t6_held_rel", 32'(key_held), 32'h0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
